// File: rtl/c2c_seq_checker_if.sv
// Receive-side link bus from the ring transceiver: data word plus link-up qualifier.
interface c2c_seq_checker_if #(
  parameter int unsigned WIDTH = 64
);
  logic [WIDTH-1:0] din;
  logic             din_valid;

  modport master (output din, output din_valid);
  modport slave  (input  din, input  din_valid);
endinterface

// File: rtl/c2c_seq_checker.sv
// Chip2chip ring link integrity checker: locks onto an incrementing counter
// stream, counts matches/mismatches while locked, and flags link loss.
module c2c_seq_checker #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned LOCK_RUN = 16,
  parameter int unsigned LOSS_RUN = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  c2c_seq_checker_if.slave    link,
  input  logic                clear,
  output logic                locked,
  output logic [1:0]          state,
  output logic                err_pulse,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    word_count,
  output logic                loss_pulse
);

  localparam int unsigned GR_W = $clog2(LOCK_RUN + 1);
  localparam int unsigned BR_W = $clog2(LOSS_RUN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_d1;
  logic              r_v1;
  logic [WIDTH-1:0]  r_expected;
  logic [GR_W-1:0]   r_good_run;
  logic [BR_W-1:0]   r_bad_run;
  logic [CNT_W-1:0]  r_err_count;
  logic [CNT_W-1:0]  r_word_count;
  logic              r_err_pulse;
  logic              r_loss_pulse;
  logic              r_locked;

  logic              w_match;
  logic [GR_W-1:0]   w_good_inc;
  logic [BR_W-1:0]   w_bad_inc;
  logic              w_lock_hit;
  logic              w_loss_hit;

  assign w_match    = (r_d1 == r_expected);
  assign w_good_inc = r_good_run + GR_W'(1);
  assign w_bad_inc  = r_bad_run + BR_W'(1);
  assign w_lock_hit = (w_good_inc == GR_W'(LOCK_RUN));
  assign w_loss_hit = (w_bad_inc == BR_W'(LOSS_RUN));

  // Next-state decode; loss of din_valid always drops back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!r_v1) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_SEARCH;
        ST_SEARCH: if (w_match && w_lock_hit) w_state_nxt = ST_LOCKED;
        ST_LOCKED: if (!w_match && w_loss_hit) w_state_nxt = ST_SEARCH;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_d1         <= '0;
      r_v1         <= 1'b0;
      r_expected   <= '0;
      r_good_run   <= '0;
      r_bad_run    <= '0;
      r_err_count  <= '0;
      r_word_count <= '0;
      r_err_pulse  <= 1'b0;
      r_loss_pulse <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_d1         <= link.din;
      r_v1         <= link.din_valid;
      r_state      <= w_state_nxt;
      r_locked     <= (w_state_nxt == ST_LOCKED);
      r_err_pulse  <= 1'b0;
      r_loss_pulse <= 1'b0;

      if (!r_v1) begin
        r_good_run <= '0;
        r_bad_run  <= '0;
        if (r_state == ST_LOCKED) r_loss_pulse <= 1'b1;
      end else begin
        // Resync to every received word so a single skip costs one error.
        r_expected <= r_d1 + WIDTH'(1);
        case (r_state)
          ST_IDLE: begin
            r_good_run <= GR_W'(1);
          end
          ST_SEARCH: begin
            if (w_match) begin
              r_good_run <= w_good_inc;
              if (w_lock_hit) r_bad_run <= '0;
            end else begin
              r_good_run <= GR_W'(1);
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_bad_run <= '0;
              if (!(&r_word_count)) r_word_count <= r_word_count + CNT_W'(1);
            end else begin
              r_err_pulse <= 1'b1;
              if (!(&r_err_count)) r_err_count <= r_err_count + CNT_W'(1);
              if (w_loss_hit) begin
                r_bad_run    <= '0;
                r_good_run   <= GR_W'(1);
                r_loss_pulse <= 1'b1;
              end else begin
                r_bad_run <= w_bad_inc;
              end
            end
          end
          default: begin
            r_good_run <= '0;
            r_bad_run  <= '0;
          end
        endcase
      end

      // Clear wins over any increment made in the same cycle.
      if (clear) begin
        r_err_count  <= '0;
        r_word_count <= '0;
      end
    end
  end

  assign locked     = r_locked;
  assign state      = r_state;
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;
  assign word_count = r_word_count;
  assign loss_pulse = r_loss_pulse;

endmodule

// File: tb/tb_c2c_seq_checker.sv
// Directed bench for c2c_seq_checker: vector table plus reset/relock and saturation sequences.
module tb_c2c_seq_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  logic        locked, err_pulse, loss_pulse;
  logic [1:0]  state;
  logic [31:0] err_count, word_count;

  logic        s_locked, s_err_pulse, s_loss_pulse;
  logic [1:0]  s_state;
  logic [1:0]  s_err_count, s_word_count;

  int total = 0;
  int bad   = 0;

  c2c_seq_checker_if #(.WIDTH(64)) link ();

  c2c_seq_checker #(.WIDTH(64), .LOCK_RUN(16), .LOSS_RUN(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .link(link), .clear(clear),
    .locked(locked), .state(state), .err_pulse(err_pulse),
    .err_count(err_count), .word_count(word_count), .loss_pulse(loss_pulse)
  );

  c2c_seq_checker #(.WIDTH(64), .LOCK_RUN(2), .LOSS_RUN(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .link(link), .clear(clear),
    .locked(s_locked), .state(s_state), .err_pulse(s_err_pulse),
    .err_count(s_err_count), .word_count(s_word_count), .loss_pulse(s_loss_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        clr;
    logic [1:0]  st;
    logic        ep;
    logic        lp;
    logic [31:0] ec;
    logic [31:0] wc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [63:0] d, input logic clr,
                              input logic [1:0] st, input logic ep, input logic lp,
                              input logic [31:0] ec, input logic [31:0] wc);
    vec_t x;
    x.v = v; x.d = d; x.clr = clr; x.st = st; x.ep = ep; x.lp = lp; x.ec = ec; x.wc = wc;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [63:0] d);
    @(negedge clk);
    link.din       = d;
    link.din_valid = v;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; clear = 1'b0; link.din = '0; link.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_pulses", 64'({err_pulse, loss_pulse}), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    rst_n = 1'b1;

    // Acquire lock on 100..115, then matches, one skip, wrap, clear cases, loss, drop-outs.
    for (int k = 0; k < 16; k++)
      add(1, 64'(100 + k), 0, (k == 15) ? 2'd2 : 2'd1, 0, 0, 0, 0);
    add(1, 64'd116, 0, 2, 0, 0, 0, 1);
    add(1, 64'd117, 0, 2, 0, 0, 0, 2);
    add(1, 64'd118, 0, 2, 0, 0, 0, 3);
    add(1, 64'd120, 0, 2, 1, 0, 1, 3);
    add(1, 64'd121, 0, 2, 0, 0, 1, 4);
    add(1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 2, 1, 0, 2, 4);
    add(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 2, 0, 0, 2, 5);
    add(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 0, 0, 2, 6);
    add(1, 64'd0, 0, 2, 0, 0, 2, 7);
    add(1, 64'd1, 0, 2, 0, 0, 2, 8);
    add(1, 64'd5, 0, 2, 1, 0, 3, 8);
    add(1, 64'd6, 0, 2, 0, 0, 3, 9);
    add(1, 64'd9, 0, 2, 1, 0, 4, 9);
    add(1, 64'd10, 0, 2, 0, 0, 4, 10);
    add(1, 64'd20, 0, 2, 1, 0, 5, 10);
    add(1, 64'd21, 0, 2, 0, 0, 5, 11);
    add(1, 64'd30, 1, 2, 1, 0, 0, 0);
    add(1, 64'd31, 0, 2, 0, 0, 0, 1);
    add(1, 64'd32, 1, 2, 0, 0, 0, 0);
    add(1, 64'd33, 0, 2, 0, 0, 0, 1);
    add(1, 64'd7, 0, 2, 1, 0, 1, 1);
    add(1, 64'd7, 0, 2, 1, 0, 2, 1);
    add(1, 64'd7, 0, 2, 1, 0, 3, 1);
    add(1, 64'd7, 0, 1, 1, 1, 4, 1);
    add(1, 64'd8, 0, 1, 0, 0, 4, 1);
    add(0, 64'd9, 0, 0, 0, 0, 4, 1);
    for (int k = 0; k < 16; k++)
      add(1, 64'(500 + k), 0, (k == 15) ? 2'd2 : 2'd1, 0, 0, 4, 1);
    add(1, 64'd516, 0, 2, 0, 0, 4, 2);
    add(0, 64'd517, 0, 0, 0, 1, 4, 2);
    add(1, 64'd518, 0, 1, 0, 0, 4, 2);
    add(1, 64'd519, 0, 1, 0, 0, 4, 2);

    n = vecs.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("r%0d_state", i - 2), 64'(state), 64'(vecs[i-2].st));
        chk($sformatf("r%0d_locked", i - 2), 64'(locked), 64'(vecs[i-2].st == 2'd2));
        chk($sformatf("r%0d_err_pulse", i - 2), 64'(err_pulse), 64'(vecs[i-2].ep));
        chk($sformatf("r%0d_loss_pulse", i - 2), 64'(loss_pulse), 64'(vecs[i-2].lp));
        chk($sformatf("r%0d_err_count", i - 2), 64'(err_count), 64'(vecs[i-2].ec));
        chk($sformatf("r%0d_word_count", i - 2), 64'(word_count), 64'(vecs[i-2].wc));
      end
      if (i < n) begin
        link.din       = vecs[i].d;
        link.din_valid = vecs[i].v;
      end else begin
        link.din_valid = 1'b0;
      end
      clear = (i >= 1 && i - 1 < n) ? vecs[i-1].clr : 1'b0;
    end

    // Asynchronous reset mid-stream returns everything to zero without a clock edge.
    @(negedge clk);
    chk("pre_rst_err_count", 64'(err_count), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_locked", 64'(locked), 64'd0);
    chk("arst_err_count", 64'(err_count), 64'd0);
    chk("arst_word_count", 64'(word_count), 64'd0);
    chk("arst_pulses", 64'({err_pulse, loss_pulse}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Relock needs the full 16-word run again.
    for (int k = 0; k < 16; k++) tick(1, 64'(1000 + k));
    tick(1, 64'd1016);
    chk("relock_w14_locked", 64'(locked), 64'd0);
    chk("relock_w14_state", 64'(state), 64'd1);
    tick(1, 64'd1017);
    chk("relock_w15_locked", 64'(locked), 64'd1);
    chk("relock_w15_word_count", 64'(word_count), 64'd0);
    chk("small_locked", 64'(s_locked), 64'd1);
    for (int k = 18; k < 22; k++) tick(1, 64'(1000 + k));
    for (int m = 30; m <= 60; m += 10) begin
      tick(1, 64'(1000 + m));
      tick(1, 64'(1001 + m));
    end
    tick(1, 64'd1062);
    tick(1, 64'd1063);
    chk("mix_state", 64'(state), 64'd2);
    chk("mix_err_count", 64'(err_count), 64'd4);
    chk("mix_word_count", 64'(word_count), 64'd10);
    chk("sat_small_word_count", 64'(s_word_count), 64'd3);
    chk("sat_small_err_count", 64'(s_err_count), 64'd3);
    chk("sat_small_state", 64'(s_state), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
